index_mask_builder: RTL and testbench



---
 rtl/index_mask_pkg.sv | 19 +
 rtl/index_onehot_dec.sv | 27 ++
 rtl/index_mask_builder.sv | 164 ++++++++++++++++
 tb/tb_index_mask_builder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/index_mask_pkg.sv
// Shared definitions for the index mask builder.
//   state_e  : builder FSM states (BUILD accumulates beats, HOLD publishes a sequence)
//   idx_w()  : width of an index port for a given sequence width
//   NULL_IDX : all-ones pattern; sliced to index width it is the "no index seen" value
package index_mask_pkg;

    typedef enum logic [0:0] {
        BUILD = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // One extra bit so that DATAWIDTH itself (and above) is representable as a null index.
    function automatic int unsigned idx_w(input int unsigned dw);
        return $clog2(dw) + 1;
    endfunction

    localparam logic [31:0] NULL_IDX = '1;

endpackage

// File: rtl/index_onehot_dec.sv
// Combinational index decoder.
//   i_Index   : bit index, idx_w(DATAWIDTH) bits wide
//   o_OneHot  : DATAWIDTH-bit one-hot of i_Index, all-zero when out of range
//   o_InRange : i_Index < DATAWIDTH (unsigned, full index width)
module index_onehot_dec
    import index_mask_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 16
) (
    input  logic [idx_w(DATAWIDTH)-1:0] i_Index,
    output logic [DATAWIDTH-1:0]        o_OneHot,
    output logic                        o_InRange
);

    logic [31:0] w_index_ext;

    assign w_index_ext = 32'(i_Index);
    assign o_InRange   = (w_index_ext < DATAWIDTH);

    always_comb begin
        o_OneHot = '0;
        for (int unsigned i = 0; i < DATAWIDTH; i++) begin
            o_OneHot[i] = (w_index_ext == i);
        end
    end

endmodule

// File: rtl/index_mask_builder.sv
// Index mask builder: ORs a stream of bit indices into a DATAWIDTH-bit sequence and
// publishes the sequence, its lowest set index and a nonzero flag on the last beat.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_Index, i_IndexValid, i_Last, o_IndexReady : index beat handshake
//   o_Sequence, o_Index, o_IndexValid           : published result (held in HOLD)
//   o_SequenceValid, i_SequenceReady            : result handshake
//   o_Error             : only when INDEX_MASK_BUILDER_ERR_EN is defined; flags a duplicate
//                         in-range index or an out-of-range index on a non-last beat
module index_mask_builder
    import index_mask_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [idx_w(DATAWIDTH)-1:0] i_Index,
    input  logic                        i_IndexValid,
    input  logic                        i_Last,
    output logic                        o_IndexReady,
    output logic [DATAWIDTH-1:0]        o_Sequence,
    output logic [idx_w(DATAWIDTH)-1:0] o_Index,
    output logic                        o_IndexValid,
    output logic                        o_SequenceValid,
    input  logic                        i_SequenceReady
`ifdef INDEX_MASK_BUILDER_ERR_EN
    ,output logic                       o_Error
`endif
);

    localparam int unsigned IW = idx_w(DATAWIDTH);
    localparam logic [IW-1:0] MIN_INIT = NULL_IDX[IW-1:0];

    state_e               r_state,   w_state_nxt;
    logic [DATAWIDTH-1:0] r_acc,     w_acc_nxt;
    logic [IW-1:0]        r_min,     w_min_nxt;
    logic                 r_any,     w_any_nxt;
    logic [DATAWIDTH-1:0] r_seq,     w_seq_nxt;
    logic [IW-1:0]        r_idx,     w_idx_nxt;
    logic                 r_idxv,    w_idxv_nxt;
    logic                 r_seqv,    w_seqv_nxt;

    logic [DATAWIDTH-1:0] w_onehot;
    logic                 w_inrange;
    logic [DATAWIDTH-1:0] w_beat_acc;
    logic [IW-1:0]        w_beat_min;
    logic                 w_beat_any;

    index_onehot_dec #(
        .DATAWIDTH (DATAWIDTH)
    ) u_dec (
        .i_Index   (i_Index),
        .o_OneHot  (w_onehot),
        .o_InRange (w_inrange)
    );

    // Accumulator state including the current beat; out-of-range beats decode to zero.
    assign w_beat_acc = r_acc | w_onehot;
    assign w_beat_min = (w_inrange && (i_Index < r_min)) ? i_Index : r_min;
    assign w_beat_any = r_any | w_inrange;

`ifdef INDEX_MASK_BUILDER_ERR_EN
    logic r_err,     w_err_nxt;
    logic r_err_out, w_err_out_nxt;
    logic w_beat_err;

    // A null index is only legal as the terminator of a sequence.
    assign w_beat_err = r_err
                      | (w_inrange && (|(r_acc & w_onehot)))
                      | (!w_inrange && !i_Last);
    assign o_Error    = r_err_out;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_min_nxt   = r_min;
        w_any_nxt   = r_any;
        w_seq_nxt   = r_seq;
        w_idx_nxt   = r_idx;
        w_idxv_nxt  = r_idxv;
        w_seqv_nxt  = r_seqv;
`ifdef INDEX_MASK_BUILDER_ERR_EN
        w_err_nxt     = r_err;
        w_err_out_nxt = r_err_out;
`endif
        unique case (r_state)
            BUILD: begin
                if (i_IndexValid) begin
                    if (i_Last) begin
                        w_seq_nxt   = w_beat_acc;
                        w_idx_nxt   = w_beat_any ? w_beat_min : '0;
                        w_idxv_nxt  = w_beat_any;
                        w_seqv_nxt  = 1'b1;
                        w_state_nxt = HOLD;
                        w_acc_nxt   = '0;
                        w_min_nxt   = MIN_INIT;
                        w_any_nxt   = 1'b0;
`ifdef INDEX_MASK_BUILDER_ERR_EN
                        w_err_out_nxt = w_beat_err;
                        w_err_nxt     = 1'b0;
`endif
                    end else begin
                        w_acc_nxt = w_beat_acc;
                        w_min_nxt = w_beat_min;
                        w_any_nxt = w_beat_any;
`ifdef INDEX_MASK_BUILDER_ERR_EN
                        w_err_nxt = w_beat_err;
`endif
                    end
                end
            end
            HOLD: begin
                if (i_SequenceReady) begin
                    w_seqv_nxt  = 1'b0;
                    w_state_nxt = BUILD;
                end
            end
            default: begin
                w_state_nxt = BUILD;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= BUILD;
            r_acc   <= '0;
            r_min   <= MIN_INIT;
            r_any   <= 1'b0;
            r_seq   <= '0;
            r_idx   <= '0;
            r_idxv  <= 1'b0;
            r_seqv  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_min   <= w_min_nxt;
            r_any   <= w_any_nxt;
            r_seq   <= w_seq_nxt;
            r_idx   <= w_idx_nxt;
            r_idxv  <= w_idxv_nxt;
            r_seqv  <= w_seqv_nxt;
        end
    end

`ifdef INDEX_MASK_BUILDER_ERR_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err     <= 1'b0;
            r_err_out <= 1'b0;
        end else begin
            r_err     <= w_err_nxt;
            r_err_out <= w_err_out_nxt;
        end
    end
`endif

    assign o_IndexReady    = (r_state == BUILD);
    assign o_Sequence      = r_seq;
    assign o_Index         = r_idx;
    assign o_IndexValid    = r_idxv;
    assign o_SequenceValid = r_seqv;

endmodule

// File: tb/tb_index_mask_builder.sv
module tb_index_mask_builder;

    localparam int DW = 16;
    localparam int IW = $clog2(DW) + 1;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [IW-1:0] i_Index;
    logic          i_IndexValid;
    logic          i_Last;
    logic          o_IndexReady;
    logic [DW-1:0] o_Sequence;
    logic [IW-1:0] o_Index;
    logic          o_IndexValid;
    logic          o_SequenceValid;
    logic          i_SequenceReady;
`ifdef INDEX_MASK_BUILDER_ERR_EN
    logic          o_Error;
`endif

    int errors = 0;
    int checks = 0;
    int cur_q[$];

    index_mask_builder #(
        .DATAWIDTH (DW)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_Index         (i_Index),
        .i_IndexValid    (i_IndexValid),
        .i_Last          (i_Last),
        .o_IndexReady    (o_IndexReady),
        .o_Sequence      (o_Sequence),
        .o_Index         (o_Index),
        .o_IndexValid    (o_IndexValid),
        .o_SequenceValid (o_SequenceValid),
        .i_SequenceReady (i_SequenceReady)
`ifdef INDEX_MASK_BUILDER_ERR_EN
        ,.o_Error        (o_Error)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Reference: the sequence is the set of in-range indices; the lowest index is the set minimum.
    function automatic void model(input int q[$], output logic [DW-1:0] seq, output int mn,
                                  output bit any, output bit err);
        seq = '0; mn = 0; any = 1'b0; err = 1'b0;
        foreach (q[k]) begin
            if (q[k] < DW) begin
                if (seq[q[k]]) err = 1'b1;
                seq[q[k]] = 1'b1;
                if (!any || q[k] < mn) mn = q[k];
                any = 1'b1;
            end else if (k != q.size() - 1) begin
                err = 1'b1;
            end
        end
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_beat(input int idx, input bit last);
        int n = 0;
        i_Index = IW'(idx); i_Last = last; i_IndexValid = 1'b1;
        while (!o_IndexReady && n < 20) begin
            step(); n++;
        end
        checks++;
        if (o_IndexReady !== 1'b1) begin
            errors++;
            $display("FAIL beat_ready_timeout: got %b want 1", o_IndexReady);
        end
        step();
        i_IndexValid = 1'b0; i_Last = 1'b0;
    endtask

    // Sends cur_q (last flag on final beat) and checks the published result one cycle later.
    task automatic send_and_check(input string name);
        logic [DW-1:0] eseq; int emn; bit eany; bit eerr;
        model(cur_q, eseq, emn, eany, eerr);
        foreach (cur_q[k]) begin
            if ($urandom_range(0, 3) == 0) begin
                i_SequenceReady = 1'b1; step(); i_SequenceReady = 1'b0;
            end
            send_beat(cur_q[k], k == cur_q.size() - 1);
            if (k != cur_q.size() - 1) begin
                checks++;
                if (o_SequenceValid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_valid: got %b want 0", name, o_SequenceValid);
                end
            end
        end
        checks++;
        if (o_SequenceValid !== 1'b1 || o_Sequence !== eseq || o_Index !== IW'(emn)
            || o_IndexValid !== eany || o_IndexReady !== 1'b0) begin
            errors++;
            $display("FAIL %s result: got v=%b seq=%h idx=%0d iv=%b rdy=%b want v=1 seq=%h idx=%0d iv=%b rdy=0",
                     name, o_SequenceValid, o_Sequence, o_Index, o_IndexValid, o_IndexReady,
                     eseq, emn, eany);
        end
`ifdef INDEX_MASK_BUILDER_ERR_EN
        checks++;
        if (o_Error !== eerr) begin
            errors++;
            $display("FAIL %s error: got %b want %b", name, o_Error, eerr);
        end
`endif
    endtask

    task automatic release_seq(input string name);
        i_SequenceReady = 1'b1;
        step();
        i_SequenceReady = 1'b0;
        checks++;
        if (o_SequenceValid !== 1'b0 || o_IndexReady !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", name, o_SequenceValid,
                     o_IndexReady);
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (o_SequenceValid !== 1'b0 || o_Sequence !== '0 || o_Index !== '0
            || o_IndexValid !== 1'b0 || o_IndexReady !== 1'b1) begin
            errors++;
            $display("FAIL %s: got v=%b seq=%h idx=%0d iv=%b rdy=%b want v=0 seq=0 idx=0 iv=0 rdy=1",
                     name, o_SequenceValid, o_Sequence, o_Index, o_IndexValid, o_IndexReady);
        end
`ifdef INDEX_MASK_BUILDER_ERR_EN
        checks++;
        if (o_Error !== 1'b0) begin
            errors++;
            $display("FAIL %s error: got %b want 0", name, o_Error);
        end
`endif
    endtask

    task automatic test_reset();
        i_rst = 1'b1; step(); step(); i_rst = 1'b0;
        check_reset_state("reset");
    endtask

    task automatic test_basic();
        cur_q = '{4, 8, 2};
        send_and_check("basic");
        checks++;
        if (o_Sequence !== 16'h0114 || o_Index !== IW'(2)) begin
            errors++;
            $display("FAIL basic_literal: got seq=%h idx=%0d want seq=0114 idx=2", o_Sequence, o_Index);
        end
        release_seq("basic");
    endtask

    task automatic test_null();
        cur_q = '{16};
        send_and_check("null");
        release_seq("null");
    endtask

    task automatic test_hold();
        logic [DW-1:0] s;
        cur_q = '{15, 0};
        send_and_check("hold");
        s = o_Sequence;
        // Source presents the next beat while the builder holds; it must not be consumed.
        i_Index = IW'(3); i_Last = 1'b1; i_IndexValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (o_SequenceValid !== 1'b1 || o_Sequence !== s || o_Sequence !== 16'h8001
                || o_Index !== '0 || o_IndexReady !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: got v=%b seq=%h idx=%0d rdy=%b want v=1 seq=8001 idx=0 rdy=0",
                         o_SequenceValid, o_Sequence, o_Index, o_IndexReady);
            end
        end
        release_seq("hold");
        step();
        i_IndexValid = 1'b0; i_Last = 1'b0;
        checks++;
        if (o_SequenceValid !== 1'b1 || o_Sequence !== 16'h0008 || o_Index !== IW'(3)) begin
            errors++;
            $display("FAIL hold_pending_beat: got v=%b seq=%h idx=%0d want v=1 seq=0008 idx=3",
                     o_SequenceValid, o_Sequence, o_Index);
        end
        release_seq("hold2");
    endtask

    task automatic test_dup();
        cur_q = '{5, 5};
        send_and_check("dup");
        release_seq("dup");
        cur_q = '{1};
        send_and_check("after_dup");
        release_seq("after_dup");
    endtask

    task automatic test_oor();
        cur_q = '{7, 20, 3};
        send_and_check("oor");
        checks++;
        if (o_Sequence !== 16'h0088 || o_Index !== IW'(3)) begin
            errors++;
            $display("FAIL oor_literal: got seq=%h idx=%0d want seq=0088 idx=3", o_Sequence, o_Index);
        end
        release_seq("oor");
    endtask

    task automatic test_reset_mid();
        send_beat(9, 1'b0);
        send_beat(10, 1'b0);
        i_rst = 1'b1; step(); i_rst = 1'b0;
        check_reset_state("reset_mid");
        cur_q = '{6};
        send_and_check("after_reset_mid");
        release_seq("after_reset_mid");
    endtask

    task automatic test_reset_hold();
        cur_q = '{2, 11};
        send_and_check("reset_hold");
        i_rst = 1'b1; step(); i_rst = 1'b0;
        check_reset_state("reset_in_hold");
    endtask

    task automatic test_random();
        for (int s = 0; s < 40; s++) begin
            int len;
            len = $urandom_range(1, 6);
            cur_q = {};
            for (int b = 0; b < len; b++) cur_q.push_back($urandom_range(0, 19));
            if ($urandom_range(0, 4) == 0) cur_q[len-1] = $urandom_range(16, 31);
            send_and_check("random");
            repeat ($urandom_range(0, 3)) begin
                step();
                checks++;
                if (o_SequenceValid !== 1'b1 || o_IndexReady !== 1'b0) begin
                    errors++;
                    $display("FAIL random_hold: got v=%b rdy=%b want v=1 rdy=0", o_SequenceValid,
                             o_IndexReady);
                end
            end
            release_seq("random");
        end
    endtask

    initial begin
        i_rst = 1'b1; i_Index = '0; i_IndexValid = 1'b0; i_Last = 1'b0; i_SequenceReady = 1'b0;
        step();
        test_reset();
        test_basic();
        test_null();
        test_hold();
        test_dup();
        test_oor();
        test_reset_mid();
        test_reset_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
